spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The parameter list SHALL be: CLK_DIV, default 4, SCK half-period in clk cycles; legal range 2..255.
REQ-002 Port: clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  the only reset, asynchronous and active-low.
REQ-004 Port: start  input  1  transfer request, sampled only while busy=0.
REQ-005 Port: data_tx  input  8  byte to send, latched on an accepted start.
REQ-006 Port: cpol  input  1  SCK idle level, latched on an accepted start.
REQ-007 Port: cpha  input  1  clock phase, latched on an accepted start.
REQ-008 Port: msb_first  input  1  bit order (1 = bit7 first), latched on an accepted start.
REQ-009 Port: miso  input  1  serial data from the slave.
REQ-010 Port: mosi  output  1  serial data to the slave.
REQ-011 Port: sck  output  1  SPI clock.
REQ-012 Port: cs  output  1  chip select, active-low.
REQ-013 Port: data_rx  output  8  last received byte.
REQ-014 Port: busy  output  1  high while a transfer is in progress.
REQ-015 Port: end_of_byte  output  1  one-clk pulse when a byte completes.

Function
REQ-016 The FSM SHALL have states IDLE, LEAD, SHIFT and TRAIL; H denotes CLK_DIV.
REQ-017 In IDLE, sck SHALL follow the cpol input, registered, one-cycle latency.
REQ-018 In IDLE, start=1 SHALL latch the configuration inputs and enter LEAD; on the next edge cs=0 and busy=1.
REQ-019 LEAD SHALL last H cycles, then SHIFT is entered with the first sck toggle.
REQ-020 SHIFT SHALL produce exactly 16 sck toggles spaced H cycles apart, then enter TRAIL.
REQ-021 The leading edge is the odd toggle (1st, 3rd, ...) and the trailing edge the even toggle.
REQ-022 cpha=0: the first bit SHALL be on mosi in the same cycle cs falls; miso is sampled on leading edges; mosi advances on trailing edges except the 16th.
REQ-023 cpha=1: mosi SHALL advance on leading edges (first bit at the 1st toggle); miso is sampled on trailing edges.
REQ-024 Bit order for both mosi and miso assembly SHALL follow the latched msb_first.
REQ-025 TRAIL SHALL last H cycles; at its end: cs=1, busy=0, data_rx is updated and end_of_byte=1 for one cycle, all in the same cycle; the FSM returns to IDLE.
REQ-026 cs SHALL be low for exactly 18H cycles per byte, and sck SHALL end at the latched cpol.
REQ-027 start while busy=1 SHALL be ignored; changing data_tx, cpol, cpha or msb_first mid-transfer SHALL have no effect.
REQ-028 start asserted in the end_of_byte cycle SHALL be accepted (IDLE entered that cycle); cs SHALL stay high for at least 1 cycle between bytes.
REQ-029 mosi SHALL hold its last value after the transfer until the next one starts.

Reset
REQ-030 rst=0 SHALL immediately force: IDLE, sck=0, cs=1, mosi=0, busy=0, end_of_byte=0, data_rx=0, and clear the shift and bit counters.
REQ-031 Reset mid-transfer SHALL abort the transfer with no end_of_byte and data_rx=0; the first start after release SHALL behave as from power-up.

Configuration
REQ-032 Macro SPI_MASTER_BURST_EN defined: start=1 in the last TRAIL cycle SHALL latch new inputs and skip cs deassertion; the new byte goes directly to LEAD; end_of_byte still pulses and busy stays 1.
REQ-033 Macro SPI_MASTER_BURST_EN undefined: there is no burst path and REQ-028 governs back-to-back starts.

Verification
REQ-034 CLK_DIV=2, cpol=0, cpha=0, msb_first=1, data_tx=0xA5, miso looped to mosi -> mosi bits 1,0,1,0,0,1,0,1; data_rx=0xA5; cs low 36 cycles; one end_of_byte pulse.
REQ-035 All four cpol/cpha modes, msb_first=0, data_tx=0x3C, slave model sends 0xC3 -> data_rx=0xC3 each time; sck idles at cpol; sampling edge as specified in REQ-022/REQ-023.
REQ-036 start pulsed again 10 cycles into a transfer with data_tx changed to 0xFF -> ignored; mosi still carries the original byte.
REQ-037 rst asserted mid-SHIFT after 5 toggles -> cs=1, sck=0, busy=0 asynchronously; no end_of_byte; data_rx=0.
REQ-038 start held high continuously across 3 bytes -> without the macro, cs goes high for at least 1 cycle between bytes; with SPI_MASTER_BURST_EN, cs stays low across all 3 bytes and there are 3 end_of_byte pulses.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: single-byte SPI master with all four cpol/cpha modes and selectable bit order.
// Define SPI_MASTER_BURST_EN to chain bytes without releasing cs.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_tx,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       msb_first,
  input  logic       miso,
  output logic       mosi,
  output logic       sck,
  output logic       cs,
  output logic [7:0] data_rx,
  output logic       busy,
  output logic       end_of_byte
);
  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, tx, rx;
  logic [4:0] tog;
  logic cfg_cpha, cfg_msb;
  logic last, done, load, do_tog;
  logic [2:0] ri;
  function automatic logic pick(input logic [7:0] d, input logic m, input logic [2:0] i);
    return m ? d[3'd7 - i] : d[i];
  endfunction
  always_comb begin
    last = cnt == 8'(CLK_DIV - 1);
    done = state == TRAIL && last;
`ifdef SPI_MASTER_BURST_EN
    load = start && (state == IDLE || done);
`else
    load = start && state == IDLE;
`endif
    do_tog = last && (state == LEAD || (state == SHIFT && tog != 5'd16));
    ri = cfg_msb ? 3'd7 - tog[3:1] : tog[3:1];
    state_nxt = state;
    if (load) state_nxt = LEAD;
    else if (done) state_nxt = IDLE;
    else if (last && state == LEAD) state_nxt = SHIFT;
    else if (last && state == SHIFT && tog == 5'd16) state_nxt = TRAIL;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sck <= 1'b0;
      cs <= 1'b1;
      mosi <= 1'b0;
      busy <= 1'b0;
      end_of_byte <= 1'b0;
      data_rx <= '0;
      cnt <= '0;
      tog <= '0;
      tx <= '0;
      rx <= '0;
      cfg_cpha <= 1'b0;
      cfg_msb <= 1'b0;
    end else begin
      end_of_byte <= done;
      cnt <= (load || last || state == IDLE) ? '0 : cnt + 8'd1;
      if (state == IDLE) sck <= cpol;
      if (done) begin
        cs <= 1'b1;
        busy <= 1'b0;
        data_rx <= rx;
      end
      // in burst mode a load here overrides the cs/busy release above
      if (load) begin
        tx <= data_tx;
        cfg_cpha <= cpha;
        cfg_msb <= msb_first;
        cs <= 1'b0;
        busy <= 1'b1;
        tog <= '0;
        sck <= cpol;
        if (!cpha) mosi <= pick(data_tx, msb_first, 3'd0);
      end
      if (do_tog) begin
        sck <= ~sck;
        tog <= tog + 5'd1;
        if (!tog[0]) begin
          if (cfg_cpha) mosi <= pick(tx, cfg_msb, tog[3:1]);
          else rx[ri] <= miso;
        end else begin
          if (cfg_cpha) rx[ri] <= miso;
          else if (tog != 5'd15) mosi <= pick(tx, cfg_msb, tog[3:1] + 3'd1);
        end
      end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master at CLK_DIV=2 with a loopback / edge-driven slave model.
module tb_spi_master;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] data_tx = '0;
  logic cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1;
  logic miso, mosi, sck, cs, busy, end_of_byte;
  logic [7:0] data_rx;
  logic loop = 1'b1, s_bit = 1'b0;
  int checks = 0, errors = 0;
`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  assign miso = loop ? mosi : s_bit;
  spi_master #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .data_tx(data_tx), .cpol(cpol), .cpha(cpha),
    .msb_first(msb_first), .miso(miso), .mosi(mosi), .sck(sck), .cs(cs),
    .data_rx(data_rx), .busy(busy), .end_of_byte(end_of_byte)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic sbit(input logic [7:0] sd, input logic sm, input int e, input logic ph);
    int i;
    i = ph ? (e == 0 ? 0 : (e - 1) / 2) : e / 2;
    i = i > 7 ? 7 : i;
    return sm ? sd[3'(7 - i)] : sd[3'(i)];
  endfunction
  // one byte: slave changes on the non-sampling edge; mosi captured on sampling edges
  task automatic xfer(input string tag, input logic [7:0] d, input logic p, input logic h,
                      input logic m, input logic lp, input logic [7:0] sd, input logic sm,
                      input logic rs, input logic [7:0] exp_rx, input logic [7:0] exp_cap);
    int edges, low, cyc;
    logic prev;
    logic [7:0] cap;
    data_tx = d; cpol = p; cpha = h; msb_first = m; loop = lp;
    s_bit = sbit(sd, sm, 0, h);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_idle_sck"}, sck, p);
    prev = sck; edges = 0; low = 0; cyc = 0; cap = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    if (!h) chk({tag, "_first_bit"}, mosi, m ? d[7] : d[0]);
    while (!end_of_byte && cyc < 200) begin
      if (!cs) low++;
      if (sck !== prev && !cs) begin
        edges++;
        if (h ? (edges % 2 == 0) : (edges % 2 == 1)) cap = {cap[6:0], mosi};
      end
      prev = sck;
      s_bit = sbit(sd, sm, edges, h);
      if (rs && cyc == 10) begin
        start = 1'b1;
        data_tx = 8'hFF;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_eob"}, end_of_byte, 1'b1);
    chk({tag, "_rx"}, data_rx, exp_rx);
    chk({tag, "_mosi_bits"}, cap, exp_cap);
    chk({tag, "_cs_low"}, low, 36);
    chk({tag, "_end_cs"}, {cs, busy, sck}, {1'b1, 1'b0, p});
    chk({tag, "_mosi_hold"}, mosi, m ? d[0] : d[7]);
    @(posedge clk);
    #1;
    chk({tag, "_eob_pulse"}, end_of_byte, 1'b0);
  endtask
  initial begin
    int tg, cyc, eobs, t2;
    logic prev;
    #2 rst = 1'b0;
    #1;
    chk("reset_async", {cs, sck, busy, mosi, end_of_byte}, 5'b10000);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rx", data_rx, 8'h00);
    rst = 1'b1;
    xfer("a5_loop", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA5, 8'hA5);
    xfer("mode0", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 8'h3C);
    xfer("mode1", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 8'h3C);
    xfer("mode2", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 8'h3C);
    xfer("mode3", 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 8'hC3, 8'h3C);
    xfer("lsb_order", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB1, 1'b1, 1'b0, 8'h8D, 8'h48);
    xfer("msb_order", 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB1, 1'b1, 1'b0, 8'hB1, 8'h12);
    xfer("restart", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 8'hA5);
    // abort after 5 sck toggles
    data_tx = 8'h5A; cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; loop = 1'b1;
    @(posedge clk);
    #1;
    prev = sck; tg = 0; cyc = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (tg < 5 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sck !== prev) tg++;
      prev = sck;
    end
    chk("abort_toggles", tg, 5);
    #2 rst = 1'b0;
    #1;
    chk("abort_async", {cs, sck, busy, end_of_byte}, 4'b1000);
    chk("abort_rx", data_rx, 8'h00);
    eobs = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (end_of_byte) eobs++;
    end
    chk("abort_no_eob", eobs, 0);
    rst = 1'b1;
    xfer("after_rst", 8'hC6, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hC6, 8'hC6);
    // start held across three bytes
    data_tx = 8'h5A; cpol = 1'b0; cpha = 1'b0; msb_first = 1'b1; loop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1; eobs = 0; cyc = 0; t2 = 0;
    while (eobs < 3 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (end_of_byte) begin
        eobs++;
        if (eobs == 2) t2 = cyc;
        chk("burst_cs_at_eob", cs, BURST ? (eobs == 3) : 1'b1);
        chk("burst_rx", data_rx, 8'h5A);
      end
      if (eobs == 2 && cyc == t2 + 3) start = 1'b0;
    end
    start = 1'b0;
    chk("burst_eobs", eobs, 3);
    repeat (5) begin
      @(posedge clk);
      #1;
      if (end_of_byte) eobs++;
    end
    chk("burst_done", {busy, cs, 8'(eobs)}, {1'b0, 1'b1, 8'd3});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
